// File: rtl/single_address_rom.sv
// 16 x 16-bit constant lookup table with one registered read port.
// Optional macro ROM_PARITY_EN adds a registered even-parity output of the word read.
module single_address_rom #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [ADDR_W-1:0] addr,
`ifdef ROM_PARITY_EN
    output logic              parity_out,
`endif
    output logic [DATA_W-1:0] data_out
);

    // Power-up value of zero matches the reset value, so the output is never X.
    logic [DATA_W-1:0] data_q = '0;
    logic [DATA_W-1:0] rom_word;

    // An unknown address falls through to the default and reloads the held word.
    always_comb begin
        rom_word = data_q;
        case (addr)
            4'h0:    rom_word = 16'h0000;
            4'h1:    rom_word = 16'h1111;
            4'h2:    rom_word = 16'h2222;
            4'h3:    rom_word = 16'h3333;
            4'h4:    rom_word = 16'h4444;
            4'h5:    rom_word = 16'h5555;
            4'h6:    rom_word = 16'h6666;
            4'h7:    rom_word = 16'h7777;
            4'h8:    rom_word = 16'h8888;
            4'h9:    rom_word = 16'h9999;
            4'hA:    rom_word = 16'hAAAA;
            4'hB:    rom_word = 16'hBBBB;
            4'hC:    rom_word = 16'hCCCC;
            4'hD:    rom_word = 16'hDDDD;
            4'hE:    rom_word = 16'hEEEE;
            4'hF:    rom_word = 16'hFFFF;
            default: rom_word = data_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
        end else if (en) begin
            data_q <= rom_word;
        end
    end

    assign data_out = data_q;

`ifdef ROM_PARITY_EN
    logic parity_q = 1'b0;

    always_ff @(posedge clk) begin
        if (rst) begin
            parity_q <= 1'b0;
        end else if (en) begin
            parity_q <= ^rom_word;
        end
    end

    assign parity_out = parity_q;
`endif

endmodule

// File: tb/tb_single_address_rom.sv
// Directed self-checking bench for single_address_rom.
// Parity checks are compiled in when ROM_PARITY_EN is defined.
module tb_single_address_rom;

    logic        clk;
    logic        rst;
    logic        en;
    logic [3:0]  addr;
    logic [15:0] data_out;
`ifdef ROM_PARITY_EN
    logic        parity_out;
`endif

    int checks = 0;
    int errors = 0;

    single_address_rom #(.DATA_W(16), .ADDR_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .addr       (addr),
`ifdef ROM_PARITY_EN
        .parity_out (parity_out),
`endif
        .data_out   (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_powerup();
        rst  = 1'b0;
        en   = 1'b0;
        addr = 4'h0;
        #2;
        checks++;
        if (data_out !== 16'h0000) begin
            errors++;
            $display("[TB] FAIL powerup_initial: got %h expected %h", data_out, 16'h0000);
        end
        en   = 1'b1;
        addr = 4'h3;
        tick();
        checks++;
        if (data_out !== 16'h3333) begin
            errors++;
            $display("[TB] FAIL powerup_first_read: got %h expected %h", data_out, 16'h3333);
        end
    endtask

    task automatic test_reset();
        rst  = 1'b1;
        en   = 1'b0;
        addr = 4'h7;
        tick();
        checks++;
        if (data_out !== 16'h0000) begin
            errors++;
            $display("[TB] FAIL reset_value: got %h expected %h", data_out, 16'h0000);
        end
`ifdef ROM_PARITY_EN
        checks++;
        if (parity_out !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_parity: got %b expected %b", parity_out, 1'b0);
        end
`endif
        rst = 1'b0;
    endtask

    // Back-to-back reads across the whole table, one address per cycle.
    task automatic test_sweep();
        logic [15:0] expected [16] = '{
            16'h0000, 16'h1111, 16'h2222, 16'h3333,
            16'h4444, 16'h5555, 16'h6666, 16'h7777,
            16'h8888, 16'h9999, 16'hAAAA, 16'hBBBB,
            16'hCCCC, 16'hDDDD, 16'hEEEE, 16'hFFFF
        };
        en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            addr = 4'(i);
            tick();
            checks++;
            if (data_out !== expected[i]) begin
                errors++;
                $display("[TB] FAIL sweep_addr_%0d: got %h expected %h", i, data_out, expected[i]);
            end
`ifdef ROM_PARITY_EN
            checks++;
            if (parity_out !== 1'b0) begin
                errors++;
                $display("[TB] FAIL sweep_parity_%0d: got %b expected %b", i, parity_out, 1'b0);
            end
`endif
        end
    endtask

    task automatic test_hold();
        en   = 1'b1;
        addr = 4'h5;
        tick();
        checks++;
        if (data_out !== 16'h5555) begin
            errors++;
            $display("[TB] FAIL hold_load: got %h expected %h", data_out, 16'h5555);
        end
        en   = 1'b0;
        addr = 4'h9;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (data_out !== 16'h5555) begin
                errors++;
                $display("[TB] FAIL hold_cycle_%0d: got %h expected %h", i, data_out, 16'h5555);
            end
        end
        en = 1'b1;
        tick();
        checks++;
        if (data_out !== 16'h9999) begin
            errors++;
            $display("[TB] FAIL hold_release: got %h expected %h", data_out, 16'h9999);
        end
    endtask

    task automatic test_reset_priority();
        en   = 1'b1;
        addr = 4'hC;
        rst  = 1'b1;
        tick();
        checks++;
        if (data_out !== 16'h0000) begin
            errors++;
            $display("[TB] FAIL reset_priority: got %h expected %h", data_out, 16'h0000);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (data_out !== 16'hCCCC) begin
            errors++;
            $display("[TB] FAIL reset_release_read: got %h expected %h", data_out, 16'hCCCC);
        end
    endtask

    initial begin
        test_powerup();
        test_reset();
        test_sweep();
        test_hold();
        test_reset_priority();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/single_address_rom.md
# single_address_rom

16-word × 16-bit read-only lookup memory with one synchronous read port. It holds a fixed constant table and returns the word at `addr` one clock after `en` is sampled high. It sits beside datapath blocks that need small constant tables, such as coefficients or microcode, and is the single-port counterpart of the dual-address ROM.

## Interface
Parameters
- `DATA_W`, 16: word width; contents below are defined for 16 only.
- `ADDR_W`, 4: address width; depth = 2**ADDR_W = 16.

Ports
- `clk` input 1: clock; all state updates on the rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `en` input 1: read enable, sampled on the rising edge of `clk`.
- `addr` input 4: word address, 0..15.
- `data_out` output 16: registered read data.
- `parity_out` output 1: present only with `ROM_PARITY_EN` (see Configuration).

## Operation
- Contents are fixed at elaboration and cannot be written. Word n = nibble n replicated four times:
  - 0→0x0000, 1→0x1111, 2→0x2222, 3→0x3333, 4→0x4444, 5→0x5555, 6→0x6666, 7→0x7777
  - 8→0x8888, 9→0x9999, A→0xAAAA, B→0xBBBB, C→0xCCCC, D→0xDDDD, E→0xEEEE, F→0xFFFF
- Each rising edge, in priority order:
  - `rst`=1: `data_out` ← 0x0000, regardless of `en`.
  - `en`=1: `data_out` ← ROM[`addr`].
  - otherwise: `data_out` holds its value.
- All 16 addresses are valid, so there is no out-of-range case.
- If `addr` or `en` is X or Z at the sampling edge, `data_out` holds its previous value. It must never go X because of an undriven input.
- The table is implemented as a case statement or constant array; it is inferred as ROM or LUT with no initialisation file.

## Timing
- Read latency is 1 cycle: address sampled at edge k appears on `data_out` just after edge k.
- Back-to-back reads are allowed every cycle with no bubbles.
- Reset value: `data_out`=0x0000 (`parity_out`=0). The power-up register initial value is also 0x0000.
- Asserting reset mid-read stream: `data_out` is 0x0000 on the reset edge. The first read after reset is released returns data one edge later.
- `en` deasserted: the output is frozen. Changes on `addr` have no effect until `en` returns high.
- There is no combinational path from inputs to outputs.

## Configuration
- `ROM_PARITY_EN` defined:
  - adds output `parity_out` = XOR of the 16 bits of the word being loaded;
  - `parity_out` is registered on the same edge and under the same `rst`/`en` rules as `data_out`.
  - With the table above, `parity_out` is always 0, because every nibble appears 4 times.
- `ROM_PARITY_EN` undefined: the port and its logic are absent, and the interface is the four inputs plus `data_out` only.

## Test plan
- Sequential sweep: `rst` for 1 cycle, then `en`=1 with `addr`=0..7 changed one per cycle → `data_out` = 0x0000, 0x1111, … 0x7777, each one edge after its address.
- Full sweep including top: `addr`=8..15 → 0x8888 … 0xFFFF, with 0xFFFF at `addr`=15.
- Hold: read `addr`=5 (0x5555), drop `en`, drive `addr`=9 for 3 cycles → `data_out` stays 0x5555; raise `en` → 0x9999 next edge.
- Reset priority: `en`=1, `addr`=12, `rst`=1 on the same edge → 0x0000. Release `rst` → 0xCCCC on the following edge.
- Power-up with no reset: first edge with `en`=1 and `addr`=3 → 0x3333. Before that edge, `data_out`=0x0000 and never X.
- With `ROM_PARITY_EN`: sweep 0..15 → `parity_out`=0 every cycle; the build without the macro has no `parity_out` port.
